// File: rtl/color_classifier_pkg.sv
// Shared encodings for the color classifier: filter select codes,
// class codes and the measurement sequencer states.
package color_classifier_pkg;

  // Filter select codes as driven on {s2,s3}
  typedef enum logic [1:0] {
    FILT_R = 2'b00,
    FILT_B = 2'b01,
    FILT_C = 2'b10,
    FILT_G = 2'b11
  } filter_t;

  // Class codes reported on class_o
  typedef enum logic [1:0] {
    CLS_YELLOW = 2'd0,
    CLS_BLUE   = 2'd1,
    CLS_WHITE  = 2'd2,
    CLS_NONE   = 2'd3
  } class_t;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_GATE   = 2'd1,
    ST_LATCH  = 2'd2
  } state_t;

  // Scan order R -> G -> B -> C -> R
  function automatic filter_t next_filter(input filter_t f);
    case (f)
      FILT_R:  return FILT_G;
      FILT_G:  return FILT_B;
      FILT_B:  return FILT_C;
      default: return FILT_R;
    endcase
  endfunction

endpackage

// File: rtl/color_classifier_edge_counter.sv
// Synchronises the sensor frequency output, detects rising edges and
// counts them into a saturating counter while enabled.
module color_classifier_edge_counter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freq,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync1_reg;
  logic             sync2_reg;
  logic             prev_reg;
  logic             rise;
  logic [CNT_W-1:0] count_reg;

  // Two-flop synchroniser plus one delay flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= freq;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~prev_reg;

  // Saturating edge counter; clear has priority over counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && rise && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // An edge arriving while already at full scale means the gate count is clipped
  assign sat   = en & rise & (count_reg == CNT_MAX);
  assign count = count_reg;

endmodule

// File: rtl/color_classifier.sv
// Color sensor front end: sequences filter channels, measures the sensor
// frequency over fixed gates, and classifies clear-channel counts with a
// debounced window match.
module color_classifier
  import color_classifier_pkg::*;
#(
  parameter int GATE_CYCLES   = 20000000,
  parameter int SETTLE_CYCLES = 50000,
  parameter int CNT_W         = 24,
  parameter int STABLE_N      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freq,
  input  logic             mode,
  input  logic [CNT_W-1:0] win_lo [3],
  input  logic [CNT_W-1:0] win_hi [3],
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             s3,
  output logic             led,
  output logic [CNT_W-1:0] cnt_r,
  output logic [CNT_W-1:0] cnt_g,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic             ovf,
  output logic [1:0]       class_o,
  output logic             class_valid
);

  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] GATE_LAST   = 32'(GATE_CYCLES - 1);
  localparam int          RUN_W       = $clog2(STABLE_N + 1);
  localparam logic [RUN_W-1:0] STABLE_LEN = RUN_W'(STABLE_N);

  state_t           state_reg, state_next;
  logic [31:0]      timer_reg, timer_next;
  filter_t          chan_reg, chan_next;
  logic [CNT_W-1:0] cnt_r_reg, cnt_g_reg, cnt_b_reg, cnt_c_reg;
  logic             ovf_reg;
  class_t           class_reg, class_next;
  class_t           run_cls_reg, run_cls_next;
  logic [RUN_W-1:0] run_len_reg, run_len_next;
  logic [CNT_W-1:0] count;
  logic             sat;
  logic             gate_en;
  logic             latch;
  logic             c_latch;
  logic [2:0]       win_hit;
  class_t           raw_cls;

  assign gate_en = (state_reg == ST_GATE);
  assign latch   = (state_reg == ST_LATCH);
  assign c_latch = latch && (chan_reg == FILT_C);

  color_classifier_edge_counter #(
    .CNT_W(CNT_W)
  ) u_edge_counter (
    .clk  (clk),
    .rst  (rst),
    .freq (freq),
    .en   (gate_en),
    .clr  (latch),
    .count(count),
    .sat  (sat)
  );

  // Sequencer state and cycle timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_SETTLE;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  // Sequencer transitions: SETTLE -> GATE -> LATCH -> SETTLE
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg + 32'd1;
    case (state_reg)
      ST_SETTLE: if (timer_reg == SETTLE_LAST) begin
        state_next = ST_GATE;
        timer_next = '0;
      end
      ST_GATE: if (timer_reg == GATE_LAST) begin
        state_next = ST_LATCH;
        timer_next = '0;
      end
      default: begin
        state_next = ST_SETTLE;
        timer_next = '0;
      end
    endcase
  end

  // Channel choice; mode only matters at the gate boundary, and C -> R
  // makes a switch into scan mode start at R
  always_comb begin
    chan_next = chan_reg;
    if (latch) begin
      chan_next = mode ? next_filter(chan_reg) : FILT_C;
    end
  end

  // Filter select register, so s2/s3 only move at LATCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chan_reg <= FILT_C;
    else     chan_reg <= chan_next;
  end

  // Capture the finished gate count into the current channel's output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r_reg <= '0;
      cnt_g_reg <= '0;
      cnt_b_reg <= '0;
      cnt_c_reg <= '0;
    end else if (latch) begin
      case (chan_reg)
        FILT_R:  cnt_r_reg <= count;
        FILT_G:  cnt_g_reg <= count;
        FILT_B:  cnt_b_reg <= count;
        default: cnt_c_reg <= count;
      endcase
    end
  end

  // Sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_reg <= 1'b0;
    else     ovf_reg <= ovf_reg | sat;
  end

  // Inclusive window match per class; lo > hi never matches
  for (genvar gi = 0; gi < 3; gi++) begin : g_win
    assign win_hit[gi] = (count >= win_lo[gi]) && (count <= win_hi[gi]);
  end

  // Lowest matching window wins
  always_comb begin
    raw_cls = CLS_NONE;
    if (win_hit[0])      raw_cls = CLS_YELLOW;
    else if (win_hit[1]) raw_cls = CLS_BLUE;
    else if (win_hit[2]) raw_cls = CLS_WHITE;
  end

  // Debounce: track the run of identical raw classes across C gates
  always_comb begin
    run_cls_next = run_cls_reg;
    run_len_next = run_len_reg;
    class_next   = class_reg;
    if (c_latch) begin
      if ((run_len_reg != '0) && (raw_cls == run_cls_reg)) begin
        if (run_len_reg != STABLE_LEN) run_len_next = run_len_reg + 1'b1;
      end else begin
        run_cls_next = raw_cls;
        run_len_next = RUN_W'(1);
      end
      if (run_len_next == STABLE_LEN) class_next = raw_cls;
    end
  end

  // Debounce state and published class
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cls_reg <= CLS_NONE;
      run_len_reg <= '0;
      class_reg   <= CLS_NONE;
    end else begin
      run_cls_reg <= run_cls_next;
      run_len_reg <= run_len_next;
      class_reg   <= class_next;
    end
  end

  assign s0          = 1'b0;
  assign s1          = 1'b1;
  assign s2          = chan_reg[1];
  assign s3          = chan_reg[0];
  assign led         = 1'b1;
  assign cnt_r       = cnt_r_reg;
  assign cnt_g       = cnt_g_reg;
  assign cnt_b       = cnt_b_reg;
  assign cnt_c       = cnt_c_reg;
  assign ovf         = ovf_reg;
  assign class_o     = class_reg;
  assign class_valid = c_latch;

endmodule

// File: tb/tb_color_classifier.sv
// Directed bench for color_classifier: overflow instance (CNT_W=4) and a
// main instance exercising classification, debounce, reset and scan mode.
module tb_color_classifier;

  localparam int CNT_W  = 24;
  localparam int GATE   = 1000;
  localparam int SETTLE = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, rst2 = 1'b1;
  logic freq = 1'b0, freq2 = 1'b0;
  logic mode = 1'b0;
  logic [CNT_W-1:0] win_lo [3];
  logic [CNT_W-1:0] win_hi [3];
  logic [3:0] w2_lo [3];
  logic [3:0] w2_hi [3];

  logic s0, s1, s2, s3, led, ovf, class_valid;
  logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b, cnt_c;
  logic [1:0] class_o;

  logic s0_2, s1_2, s2_2, s3_2, led_2, ovf2, class_valid2;
  logic [3:0] cnt_r2, cnt_g2, cnt_b2, cnt_c2;
  logic [1:0] class_o2;

  int half = 20, half2 = 2;
  int fcnt = 0, fcnt2 = 0;
  int checks = 0, errors = 0;

  color_classifier #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W), .STABLE_N(3)) dut (
    .clk(clk), .rst(rst), .freq(freq), .mode(mode), .win_lo(win_lo), .win_hi(win_hi),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .led(led),
    .cnt_r(cnt_r), .cnt_g(cnt_g), .cnt_b(cnt_b), .cnt_c(cnt_c),
    .ovf(ovf), .class_o(class_o), .class_valid(class_valid));

  color_classifier #(.GATE_CYCLES(200), .SETTLE_CYCLES(SETTLE), .CNT_W(4), .STABLE_N(3)) dut2 (
    .clk(clk), .rst(rst2), .freq(freq2), .mode(1'b0), .win_lo(w2_lo), .win_hi(w2_hi),
    .s0(s0_2), .s1(s1_2), .s2(s2_2), .s3(s3_2), .led(led_2),
    .cnt_r(cnt_r2), .cnt_g(cnt_g2), .cnt_b(cnt_b2), .cnt_c(cnt_c2),
    .ovf(ovf2), .class_o(class_o2), .class_valid(class_valid2));

  // Sensor models: square waves of period 2*half clocks, synchronous to clk
  always @(negedge clk) begin
    fcnt++;
    if (fcnt >= half) begin fcnt = 0; freq = ~freq; end
    fcnt2++;
    if (fcnt2 >= half2) begin fcnt2 = 0; freq2 = ~freq2; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_win(input int l0, h0, l1, h1, l2, h2);
    win_lo[0] = CNT_W'(l0); win_hi[0] = CNT_W'(h0);
    win_lo[1] = CNT_W'(l1); win_hi[1] = CNT_W'(h1);
    win_lo[2] = CNT_W'(l2); win_hi[2] = CNT_W'(h2);
  endtask

  // Wait (bounded) for a class_valid pulse of the main instance
  task automatic wait_valid(input string tag);
    int n = 0;
    while (class_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check({tag, "_valid"}, 32'(class_valid), 32'd1);
  endtask

  // One C gate: class before update, class after update, pulse is one cycle
  task automatic next_gate(input string tag, input logic [1:0] pre, input logic [1:0] post);
    wait_valid(tag);
    check({tag, "_pre"}, 32'(class_o), 32'(pre));
    @(posedge clk); #1;
    check({tag, "_post"}, 32'(class_o), 32'(post));
    check({tag, "_pulse"}, 32'(class_valid), 32'd0);
  endtask

  // Wait (bounded) for the filter select to move, then check the new code
  task automatic wait_chan(input string tag, input logic [1:0] exp);
    logic [1:0] prev = {s2, s3};
    int n = 0;
    while ({s2, s3} === prev && n < 3000) begin @(negedge clk); n++; end
    check(tag, 32'({s2, s3}), 32'(exp));
  endtask

  initial begin
    int n;
    set_win(20, 30, 40, 60, 0, 5);
    for (int i = 0; i < 3; i++) begin w2_lo[i] = 4'd0; w2_hi[i] = 4'd15; end
    repeat (5) @(negedge clk);

    // Reset values of the main instance
    check("rst_s0", 32'(s0), 32'd0);
    check("rst_s1", 32'(s1), 32'd1);
    check("rst_led", 32'(led), 32'd1);
    check("rst_s2s3", 32'({s2, s3}), 32'd2);
    check("rst_cnt_r", 32'(cnt_r), 32'd0);
    check("rst_cnt_g", 32'(cnt_g), 32'd0);
    check("rst_cnt_b", 32'(cnt_b), 32'd0);
    check("rst_cnt_c", 32'(cnt_c), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_class", 32'(class_o), 32'd3);
    check("rst_valid", 32'(class_valid), 32'd0);

    // Saturation: 50 edges into a 4-bit counter
    rst2 = 1'b0;
    check("ovf2_init", 32'(ovf2), 32'd0);
    for (int g = 0; g < 2; g++) begin
      n = 0;
      while (class_valid2 !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      check("sat_valid", 32'(class_valid2), 32'd1);
      @(posedge clk); #1;
      check("sat_cnt_c", 32'(cnt_c2), 32'd15);
      check("sat_ovf", 32'(ovf2), 32'd1);
    end
    @(negedge clk); rst2 = 1'b1; #1;
    check("sat_ovf_rst", 32'(ovf2), 32'd0);
    check("sat_cnt_rst", 32'(cnt_c2), 32'd0);

    // Clear-channel classification with debounce, 25 edges per gate
    @(negedge clk); rst = 1'b0;
    next_gate("g1", 2'd3, 2'd3);
    check("g1_cnt_c", 32'(cnt_c), 32'd25);
    check("g1_s2s3", 32'({s2, s3}), 32'd2);
    next_gate("g2", 2'd3, 2'd3);
    set_win(31, 0, 20, 30, 0, 5);          // raw class 1 (window 0 empty)
    next_gate("g3", 2'd3, 2'd3);
    set_win(20, 30, 40, 60, 0, 5);         // raw class 0
    next_gate("g4", 2'd3, 2'd3);
    next_gate("g5", 2'd3, 2'd3);
    next_gate("g6", 2'd3, 2'd0);
    set_win(26, 40, 0, 24, 25, 25);        // raw class 2 on exact bounds
    next_gate("g7", 2'd0, 2'd0);
    next_gate("g8", 2'd0, 2'd0);
    next_gate("g9", 2'd0, 2'd2);
    set_win(26, 50, 30, 20, 0, 24);        // no match -> class 3
    next_gate("g10", 2'd2, 2'd2);
    next_gate("g11", 2'd2, 2'd2);
    next_gate("g12", 2'd2, 2'd3);
    set_win(10, 50, 20, 30, 25, 25);       // overlapping windows -> class 0
    next_gate("g13", 2'd3, 2'd3);
    next_gate("g14", 2'd3, 2'd3);
    next_gate("g15", 2'd3, 2'd0);
    check("g15_cnt_c", 32'(cnt_c), 32'd25);

    // Reset in the middle of a gate
    repeat (400) @(negedge clk);
    rst = 1'b1; #1;
    check("mid_rst_class", 32'(class_o), 32'd3);
    check("mid_rst_cnt_c", 32'(cnt_c), 32'd0);
    check("mid_rst_s2s3", 32'({s2, s3}), 32'd2);
    check("mid_rst_valid", 32'(class_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (class_valid !== 1'b1 && n < 3000) begin @(posedge clk); n++; @(negedge clk); end
    check("mid_rst_latency", 32'(n), 32'(SETTLE + GATE));
    @(posedge clk); #1;
    check("mid_rst_cnt_c2", 32'(cnt_c), 32'd25);

    // Four-channel scan, 50 edges per gate
    @(negedge clk);
    rst = 1'b1; mode = 1'b1; half = 10;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    next_gate("m1_c0", 2'd3, 2'd3);
    check("m1_cnt_c0", 32'(cnt_c), 32'd50);
    check("m1_to_r", 32'({s2, s3}), 32'd0);
    wait_chan("m1_to_g", 2'b11);
    check("m1_cnt_r", 32'(cnt_r), 32'd50);
    wait_chan("m1_to_b", 2'b01);
    check("m1_cnt_g", 32'(cnt_g), 32'd50);
    wait_chan("m1_to_c", 2'b10);
    check("m1_cnt_b", 32'(cnt_b), 32'd50);
    next_gate("m1_c1", 2'd3, 2'd3);
    check("m1_cnt_c1", 32'(cnt_c), 32'd50);
    check("m1_wrap_r", 32'({s2, s3}), 32'd0);

    // Drop back to clear-only in the middle of the R gate
    repeat (300) @(negedge clk);
    mode = 1'b0;
    wait_chan("m0_to_c", 2'b10);
    next_gate("m0_c", 2'd3, 2'd0);
    check("m0_stay_c", 32'({s2, s3}), 32'd2);
    check("m0_ovf", 32'(ovf), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_classifier.md
COLOR_CLASSIFIER -- requirements
Module: color_classifier

Interface
REQ-001 Parameter GATE_CYCLES, default 20000000, clk cycles per counting gate (>=2).
REQ-002 Parameter SETTLE_CYCLES, default 50000, clk cycles discarded after each filter change (>=1).
REQ-003 Parameter CNT_W, default 24, width of every edge counter and threshold.
REQ-004 Parameter STABLE_N, default 3, consecutive identical raw classes required before class_o updates (>=1).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high. Ports: clk (input, 1, rising-edge system clock); rst (input, 1, asynchronous active-high reset).
REQ-006 freq  input  1  sensor output; asynchronous to clk.
REQ-007 mode  input  1  0 = clear-channel only, 1 = four-channel scan.
REQ-008 win_lo[0..2], win_hi[0..2]  input  CNT_W each  inclusive clear-count windows for classes 0..2.
REQ-009 s0, s1  output  1 each  sensor frequency scaling; constant 0/1.
REQ-010 s2, s3  output  1 each  filter select: R=00, B=01, C=10, G=11 ({s2,s3}).
REQ-011 led  output  1  illumination enable.
REQ-012 cnt_r, cnt_g, cnt_b, cnt_c  output  CNT_W each  last completed gate count per channel.
REQ-013 ovf  output  1  sticky; set when any gate count saturated.
REQ-014 class_o  output  2  debounced class (0 yellow, 1 blue, 2 white, 3 none).
REQ-015 class_valid  output  1  one-cycle pulse per completed clear-channel gate.

Function
REQ-016 freq SHALL pass a 2-flop synchroniser and a rising-edge detector; one count per detected edge; detection latency 3 clk.
REQ-017 FSM states SETTLE, GATE, LATCH; SETTLE lasts SETTLE_CYCLES, GATE lasts GATE_CYCLES, LATCH lasts 1 cycle, then SETTLE.
REQ-018 Edges SHALL be counted only in GATE; an edge detected on the final GATE cycle SHALL be included.
REQ-019 Counter SHALL saturate at 2^CNT_W-1 and never wrap; saturation sets ovf.
REQ-020 In LATCH the count SHALL be copied to the current channel's cnt_* output; the working counter SHALL clear on entry to SETTLE.
REQ-021 mode=1: channel order R,G,B,C, advancing in LATCH, C wrapping to R; mode=0: channel fixed at C.
REQ-022 mode SHALL be sampled only in LATCH; changes mid-gate SHALL NOT affect the current gate; switching to mode 1 SHALL start at R.
REQ-023 s2/s3 SHALL change only in LATCH (registered, glitch-free).
REQ-024 Raw class on each C gate: count within [win_lo[k],win_hi[k]] for lowest k=0..2 matching, else 3; overlapping windows resolve to lowest k; win_lo>win_hi makes window k empty.
REQ-025 class_valid SHALL pulse in the LATCH cycle of every C gate, one cycle after which class_o reflects the debounce result.
REQ-026 class_o SHALL change only when the same raw class has occurred on STABLE_N consecutive C gates; a differing raw class restarts the run at 1.
REQ-027 ovf SHALL clear only on reset.

Reset
REQ-028 Reset SHALL force: state SETTLE, timer 0, counter 0, channel C (mode 0) or R (mode 1, sampled first LATCH), s0=0, s1=1, s2=1, s3=0, led=1, cnt_*=0, ovf=0, class_o=3, class_valid=0, debounce run 0.
REQ-029 Reset asserted mid-gate SHALL discard the partial count; no cnt_* or class_o update.
REQ-030 Synchroniser flops SHALL reset to 0 so no edge is detected in the first cycle after release.

Structure
REQ-031 Shared package holds channel encodings (R/B/C/G filter codes), class codes 0..3 and FSM state enumeration.
REQ-032 One sub-module edge_counter (synchroniser, edge detect, saturating counter, enable, clear) SHALL be instantiated once.

Verification
REQ-033 mode=0, GATE_CYCLES=1000, SETTLE_CYCLES=10, freq period 40 clk, window0=[20,30] -> cnt_c=25, class_o=0 after third class_valid.
REQ-034 mode=1, freq period 20 clk -> cnt_r, cnt_g, cnt_b, cnt_c each 50; {s2,s3} sequence 00,11,01,10 repeating.
REQ-035 CNT_W=4, freq period 4 clk, GATE_CYCLES=200 -> cnt_c=15, ovf=1 held until rst.
REQ-036 Raw classes 0,0,1,0,0,0 with STABLE_N=3 -> class_o stays 3 until sixth gate, then 0.
REQ-037 rst pulsed mid-GATE -> all outputs at reset values, next class_valid only after a full SETTLE+GATE.
REQ-038 Overlapping windows 0=[10,50], 1=[20,30], count 25 -> raw class 0; count 60 -> raw class 3.
